// File: rtl/rat_mp.sv
// rat_mp: register alias table with per-areg busy/tag/value, a commit path and
// registered multi-port operand lookup that sees same-cycle rename/commit/flush.
module rat_mp #(
  parameter int NUM_AREGS = 4,
  parameter int ROB_DEPTH = 4,
  parameter int DATA_W    = 16,
  parameter int NUM_RD    = 2,
  localparam int AREG_W   = $clog2(NUM_AREGS),
  localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_rob_valid,
  input  logic [TAG_W-1:0]           i_rob_addr,
  input  logic [AREG_W-1:0]          i_rob_dst_addr,
  input  logic                       i_cmt_valid,
  input  logic [TAG_W-1:0]           i_cmt_tag,
  input  logic [AREG_W-1:0]          i_cmt_dst_addr,
  input  logic [DATA_W-1:0]          i_cmt_data,
  input  logic                       i_flush,
  input  logic [NUM_RD-1:0]          i_rs_req,
  input  logic [NUM_RD*AREG_W-1:0]   i_rs_addr,
  output logic [NUM_RD-1:0]          o_rs_valid,
  output logic [NUM_RD-1:0]          o_rs_tag_valid,
  output logic [NUM_RD*TAG_W-1:0]    o_rs_tag,
  output logic [NUM_RD-1:0]          o_rs_val_valid,
  output logic [NUM_RD*DATA_W-1:0]   o_rs_val
);
  logic [NUM_AREGS-1:0]              busy_q, busy_d;
  logic [NUM_AREGS-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [NUM_AREGS-1:0][DATA_W-1:0]  arf_q, arf_d;
  logic [NUM_RD-1:0]                 rs_valid_q, rs_valid_d;
  logic [NUM_RD-1:0]                 rs_tag_valid_q, rs_tag_valid_d;
  logic [NUM_RD*TAG_W-1:0]           rs_tag_q, rs_tag_d;
  logic [NUM_RD-1:0]                 rs_val_valid_q, rs_val_valid_d;
  logic [NUM_RD*DATA_W-1:0]          rs_val_q, rs_val_d;
  // Commit first, then rename, then flush: later steps override earlier ones.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    arf_d  = arf_q;
    if (i_cmt_valid) begin
      arf_d[i_cmt_dst_addr] = i_cmt_data;
      if (busy_q[i_cmt_dst_addr] && tag_q[i_cmt_dst_addr] == i_cmt_tag)
        busy_d[i_cmt_dst_addr] = 1'b0;
    end
    if (i_flush)
      busy_d = '0;
    else if (i_rob_valid) begin
      busy_d[i_rob_dst_addr] = 1'b1;
      tag_d[i_rob_dst_addr]  = i_rob_addr;
    end
  end
  // Lookups read the next-state table so same-cycle updates are forwarded.
  always_comb begin
    rs_valid_d     = i_rs_req;
    rs_tag_valid_d = '0;
    rs_tag_d       = '0;
    rs_val_valid_d = '0;
    rs_val_d       = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (i_rs_req[k]) begin
        if (busy_d[i_rs_addr[k*AREG_W +: AREG_W]]) begin
          rs_tag_valid_d[k]           = 1'b1;
          rs_tag_d[k*TAG_W +: TAG_W]  = tag_d[i_rs_addr[k*AREG_W +: AREG_W]];
        end else begin
          rs_val_valid_d[k]           = 1'b1;
          rs_val_d[k*DATA_W +: DATA_W] = arf_d[i_rs_addr[k*AREG_W +: AREG_W]];
        end
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      busy_q         <= '0;
      tag_q          <= '0;
      arf_q          <= '0;
      rs_valid_q     <= '0;
      rs_tag_valid_q <= '0;
      rs_tag_q       <= '0;
      rs_val_valid_q <= '0;
      rs_val_q       <= '0;
    end else begin
      busy_q         <= busy_d;
      tag_q          <= tag_d;
      arf_q          <= arf_d;
      rs_valid_q     <= rs_valid_d;
      rs_tag_valid_q <= rs_tag_valid_d;
      rs_tag_q       <= rs_tag_d;
      rs_val_valid_q <= rs_val_valid_d;
      rs_val_q       <= rs_val_d;
    end
  end
  assign o_rs_valid     = rs_valid_q;
  assign o_rs_tag_valid = rs_tag_valid_q;
  assign o_rs_tag       = rs_tag_q;
  assign o_rs_val_valid = rs_val_valid_q;
  assign o_rs_val       = rs_val_q;
endmodule
